// File: rtl/crp16_alu_mc.sv
// Multicycle CRP16 execute-stage ALU: 1-cycle base ops plus iterative unsigned mul/div.
// Optional ROR/ROL on select 1100/1101 when CRP16_ALU_MC_ROTATE_EN is defined.
module crp16_alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z
);
    localparam int AW = $clog2(WIDTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;   // multiplicand for mul, divisor for div
    logic [1:0]         mop;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0] r1;
    logic             v1, c1;
    logic [WIDTH:0]   sum;
    logic [AW-1:0]    amt;

    always_comb begin
        r1  = '0;
        v1  = 1'b0;
        c1  = 1'b0;
        sum = '0;
        amt = y[AW-1:0];
        case (select)
            4'h0: begin
                sum = {1'b0, x} + {1'b0, y};
                r1  = sum[WIDTH-1:0];
                c1  = sum[WIDTH];
                v1  = (x[WIDTH-1] == y[WIDTH-1]) && (r1[WIDTH-1] != x[WIDTH-1]);
            end
            4'h1: begin
                sum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
                r1  = sum[WIDTH-1:0];
                c1  = sum[WIDTH];
                v1  = (x[WIDTH-1] != y[WIDTH-1]) && (r1[WIDTH-1] == y[WIDTH-1]);
            end
            4'h2: r1 = x >> amt;
            4'h3: r1 = $signed(x) >>> amt;
            4'h4: r1 = x << amt;
            4'h5: r1 = x & y;
            4'h6: r1 = x | y;
            4'h7: r1 = x ^ y;
`ifdef CRP16_ALU_MC_ROTATE_EN
            // shift by WIDTH yields 0, so amt=0 degenerates to a plain copy
            4'hC: begin
                r1 = (x >> amt) | (x << (WIDTH - int'(amt)));
                c1 = (amt != '0) && r1[WIDTH-1];
            end
            4'hD: begin
                r1 = (x << amt) | (x >> (WIDTH - int'(amt)));
                c1 = (amt != '0) && r1[0];
            end
`endif
            default: ;
        endcase
    end

    // One shift-add (mul) or restoring-subtract (div) step per cycle
    logic [WIDTH:0]     madd, rsh, dsub;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   rm;
    logic               vm;

    always_comb begin
        madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rsh  = acc[2*WIDTH-1:WIDTH-1];
        dsub = rsh - {1'b0, opnd};
        if (!mop[1])
            acc_nx = acc[0] ? {madd, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        else if (rsh >= {1'b0, opnd})
            acc_nx = {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nx = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        case (mop)
            2'b00:   begin rm = acc_nx[WIDTH-1:0];       vm = |acc_nx[2*WIDTH-1:WIDTH]; end
            2'b01:   begin rm = acc_nx[2*WIDTH-1:WIDTH]; vm = 1'b0;                     end
            2'b10:   begin rm = acc_nx[WIDTH-1:0];       vm = (opnd == '0);             end
            default: begin rm = acc_nx[2*WIDTH-1:WIDTH]; vm = (opnd == '0);             end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_out <= '0;
            v       <= 1'b0;
            c       <= 1'b0;
            n       <= 1'b0;
            z       <= 1'b1;
            acc     <= '0;
            opnd    <= '0;
            mop     <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (select[3:2] == 2'b10) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        count <= '0;
                        mop   <= select[1:0];
                        opnd  <= select[1] ? y : x;
                        acc   <= {{WIDTH{1'b0}}, (select[1] ? x : y)};
                    end else begin
                        alu_out <= r1;
                        v       <= v1;
                        c       <= c1;
                        n       <= r1[WIDTH-1];
                        z       <= (r1 == '0);
                        done    <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= acc_nx;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        alu_out <= rm;
                        v       <= vm;
                        c       <= 1'b0;
                        n       <= rm[WIDTH-1];
                        z       <= (rm == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
